// File: rtl/fifo_spram_stream.sv
// Streaming FIFO on parallel 16-bit single-port RAM banks. Writes and reads share
// one RAM port; a one-cycle starvation guard lets a blocked read through, and a
// 2-entry output buffer sustains back-to-back words toward the consumer.
module fifo_spram_stream #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned AF_THRESH  = DEPTH - 4,
    parameter int unsigned AE_THRESH  = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     input_valid,
    input  logic [DATA_WIDTH-1:0]    data_in,
    output logic                     ready_for_input,
    output logic                     output_valid,
    output logic [DATA_WIDTH-1:0]    data_out,
    input  logic                     ready_for_output,
    output logic                     fifo_empty,
    output logic                     fifo_full,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH)+1:0] element_count
);
    localparam int unsigned NUM_BANKS = DATA_WIDTH / 16;
    localparam int unsigned ADDR_W    = $clog2(DEPTH);
    localparam int unsigned RCNT_W    = ADDR_W + 1;
    localparam int unsigned CNT_W     = ADDR_W + 2;

    logic [ADDR_W-1:0]     wr_ptr;
    logic [ADDR_W-1:0]     rd_ptr;
    logic [ADDR_W-1:0]     ram_addr;
    logic [RCNT_W-1:0]     ram_count;
    logic [RCNT_W-1:0]     ram_count_nxt;
    logic [CNT_W-1:0]      count_nxt;
    logic                  inflight;
    logic                  rd_pending;
    logic                  rd_pending_nxt;
    logic                  buf1_valid;
    logic [DATA_WIDTH-1:0] buf1_data;
    logic [DATA_WIDTH-1:0] ram_do;
    logic                  wr_en;
    logic                  pop;
    logic                  rd_eligible;
    logic                  rd_issue;
    logic [2:0]            ob_load;

    // Port arbitration: writes win, reads fill the output buffer when there is room.
    always_comb begin
        wr_en          = input_valid & ready_for_input & ~flush;
        pop            = output_valid & ready_for_output;
        ob_load        = 3'(output_valid) + 3'(buf1_valid) + 3'(inflight);
        rd_eligible    = (ram_count != '0) & ~flush & (ob_load < (3'd2 + 3'(pop)));
        rd_issue       = rd_eligible & ~wr_en;
        rd_pending_nxt = rd_pending ? ~rd_issue
                                    : (rd_eligible & wr_en & ~output_valid & ~buf1_valid);
        ram_addr       = wr_en ? wr_ptr : rd_ptr;
        ram_count_nxt  = ram_count + RCNT_W'(wr_en) - RCNT_W'(rd_issue);
        count_nxt      = element_count + CNT_W'(wr_en) - CNT_W'(pop);
    end

    // Single-port RAM banks sharing one address; read data registered one cycle later.
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [15:0] mem [DEPTH];
        logic [15:0] bank_do;

        // One access per cycle: write has the port, otherwise an issued read.
        always_ff @(posedge clk) begin
            if (wr_en) begin
                mem[ram_addr] <= data_in[b*16 +: 16];
            end else if (rd_issue) begin
                bank_do <= mem[ram_addr];
            end
        end

        assign ram_do[b*16 +: 16] = bank_do;
    end

    // Pointers, occupancy, starvation guard and registered flags.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            ram_count       <= '0;
            inflight        <= 1'b0;
            rd_pending      <= 1'b0;
            element_count   <= '0;
            fifo_empty      <= 1'b1;
            fifo_full       <= 1'b0;
            almost_full     <= 1'b0;
            almost_empty    <= 1'b1;
            ready_for_input <= 1'b1;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (rd_issue) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            ram_count       <= ram_count_nxt;
            inflight        <= rd_issue;
            rd_pending      <= rd_pending_nxt;
            element_count   <= count_nxt;
            fifo_empty      <= (count_nxt == '0);
            fifo_full       <= (ram_count_nxt == RCNT_W'(DEPTH));
            almost_full     <= (count_nxt >= CNT_W'(AF_THRESH));
            almost_empty    <= (count_nxt <= CNT_W'(AE_THRESH));
            ready_for_input <= (ram_count_nxt != RCNT_W'(DEPTH)) & ~rd_pending_nxt;
        end
    end

    // Two-entry output buffer: data_out is the head, buf1 holds the next word.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            output_valid <= 1'b0;
            data_out     <= '0;
            buf1_valid   <= 1'b0;
            buf1_data    <= '0;
        end else if (pop) begin
            if (buf1_valid) begin
                data_out   <= buf1_data;
                buf1_valid <= inflight;
                if (inflight) begin
                    buf1_data <= ram_do;
                end
            end else begin
                output_valid <= inflight;
                if (inflight) begin
                    data_out <= ram_do;
                end
            end
        end else if (inflight) begin
            if (output_valid) begin
                buf1_valid <= 1'b1;
                buf1_data  <= ram_do;
            end else begin
                output_valid <= 1'b1;
                data_out     <= ram_do;
            end
        end
    end

endmodule

// File: tb/tb_fifo_spram_stream.sv
// Directed bench for fifo_spram_stream: cycle-exact vector table for the basic
// stream, plus handshake sequences checked by a scoreboard and occupancy model.
module tb_fifo_spram_stream;
    localparam int unsigned DW    = 48;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AF    = 6;
    localparam int unsigned AE    = 2;
    localparam int unsigned CW    = $clog2(DEPTH) + 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          input_valid;
    logic [DW-1:0] data_in;
    logic          ready_for_input;
    logic          output_valid;
    logic [DW-1:0] data_out;
    logic          ready_for_output;
    logic          fifo_empty;
    logic          fifo_full;
    logic          almost_full;
    logic          almost_empty;
    logic [CW-1:0] element_count;

    int checks = 0;
    int errors = 0;
    int model_cnt = 0;
    int pops_seen = 0;
    logic [DW-1:0] sb_q[$];

    always #5 clk = ~clk;

    fifo_spram_stream #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .AF_THRESH (AF),
        .AE_THRESH (AE)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .flush           (flush),
        .input_valid     (input_valid),
        .data_in         (data_in),
        .ready_for_input (ready_for_input),
        .output_valid    (output_valid),
        .data_out        (data_out),
        .ready_for_output(ready_for_output),
        .fifo_empty      (fifo_empty),
        .fifo_full       (fifo_full),
        .almost_full     (almost_full),
        .almost_empty    (almost_empty),
        .element_count   (element_count)
    );

    typedef struct {
        logic          rst;
        logic          iv;
        logic [DW-1:0] din;
        logic          rdy;
        logic          e_rfi;
        logic          e_ov;
        logic [DW-1:0] e_dout;
        logic [CW-1:0] e_cnt;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: model handshakes seen before the edge, then sample #1 after it.
    task automatic tick();
        logic          push;
        logic          popd;
        logic [DW-1:0] pd;
        logic [DW-1:0] pin;
        push = input_valid & ready_for_input & ~flush & ~reset;
        popd = output_valid & ready_for_output;
        pd   = data_out;
        pin  = data_in;
        @(posedge clk);
        #1;
        if (reset || flush) begin
            sb_q.delete();
            model_cnt = 0;
        end else begin
            if (popd) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_order: popped %0h with nothing expected", pd);
                end else begin
                    check("pop_order", 64'(pd), 64'(sb_q.pop_front()));
                    pops_seen++;
                end
            end
            if (push) sb_q.push_back(pin);
            model_cnt = model_cnt + int'(push) - int'(popd);
        end
        check("element_count", 64'(element_count), 64'(model_cnt));
        check("fifo_empty",    64'(fifo_empty),    64'(model_cnt == 0));
        check("almost_full",   64'(almost_full),   64'(model_cnt >= AF));
        check("almost_empty",  64'(almost_empty),  64'(model_cnt <= AE));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Offer n sequential words with handshake within a cycle budget.
    task automatic offer(input int n, input logic [DW-1:0] base, input int budget,
                         output int acc_n, output int max_low);
        int   low;
        logic acc;
        low = 0;
        acc_n = 0;
        max_low = 0;
        for (int c = 0; c < budget && acc_n < n; c++) begin
            input_valid = 1'b1;
            data_in = base + DW'(acc_n);
            acc = ready_for_input;
            if (!ready_for_input) begin
                low++;
                if (low > max_low) max_low = low;
            end else begin
                low = 0;
            end
            tick();
            if (acc) acc_n++;
        end
        input_valid = 1'b0;
    endtask

    task automatic wait_ov(input string name);
        for (int k = 0; k < 10 && !output_valid; k++) tick();
        check(name, 64'(output_valid), 64'(1));
    endtask

    initial begin
        int n;
        int ml;
        int p0;
        reset = 1'b0;
        flush = 1'b0;
        input_valid = 1'b0;
        data_in = '0;
        ready_for_output = 1'b0;

        // Basic stream: reset, 4 words, first output 3 cycles after first write.
        vecs[0]  = '{1'b1, 1'b0, 48'h0,    1'b0, 1'b1, 1'b0, 48'h0,    5'd0};
        vecs[1]  = '{1'b0, 1'b1, 48'h1111, 1'b1, 1'b1, 1'b0, 48'h0,    5'd1};
        vecs[2]  = '{1'b0, 1'b1, 48'h2222, 1'b1, 1'b0, 1'b0, 48'h0,    5'd2};
        vecs[3]  = '{1'b0, 1'b1, 48'h3333, 1'b1, 1'b1, 1'b0, 48'h0,    5'd2};
        vecs[4]  = '{1'b0, 1'b1, 48'h3333, 1'b1, 1'b0, 1'b1, 48'h1111, 5'd3};
        vecs[5]  = '{1'b0, 1'b1, 48'h4444, 1'b1, 1'b1, 1'b0, 48'h0,    5'd2};
        vecs[6]  = '{1'b0, 1'b1, 48'h4444, 1'b1, 1'b0, 1'b1, 48'h2222, 5'd3};
        vecs[7]  = '{1'b0, 1'b0, 48'h0,    1'b1, 1'b1, 1'b0, 48'h0,    5'd2};
        vecs[8]  = '{1'b0, 1'b0, 48'h0,    1'b1, 1'b1, 1'b1, 48'h3333, 5'd2};
        vecs[9]  = '{1'b0, 1'b0, 48'h0,    1'b1, 1'b1, 1'b1, 48'h4444, 5'd1};
        vecs[10] = '{1'b0, 1'b0, 48'h0,    1'b1, 1'b1, 1'b0, 48'h0,    5'd0};

        for (int i = 0; i < 11; i++) begin
            reset = vecs[i].rst;
            input_valid = vecs[i].iv;
            data_in = vecs[i].din;
            ready_for_output = vecs[i].rdy;
            tick();
            check($sformatf("v%0d_ready_for_input", i), 64'(ready_for_input), 64'(vecs[i].e_rfi));
            check($sformatf("v%0d_output_valid", i), 64'(output_valid), 64'(vecs[i].e_ov));
            check($sformatf("v%0d_count", i), 64'(element_count), 64'(vecs[i].e_cnt));
            if (vecs[i].e_ov || vecs[i].rst)
                check($sformatf("v%0d_data_out", i), 64'(data_out), 64'(vecs[i].e_dout));
            if (vecs[i].rst)
                check("reset_fifo_full", 64'(fifo_full), 64'(0));
        end
        input_valid = 1'b0;

        // Fill with consumer stalled: 8 in RAM + 2 in output buffer.
        ready_for_output = 1'b0;
        offer(12, 48'h2000, 40, n, ml);
        check("t2_accepted", 64'(n), 64'(10));
        check("t2_fifo_full", 64'(fifo_full), 64'(1));
        check("t2_ready_low", 64'(ready_for_input), 64'(0));
        check("t2_count", 64'(element_count), 64'(10));
        check("t2_head", 64'(data_out), 64'(48'h2000));
        p0 = pops_seen;
        ready_for_output = 1'b1;
        idle(30);
        check("t2_drained", 64'(pops_seen - p0), 64'(10));

        // Continuous producer and consumer: one-cycle starvation stalls only.
        p0 = pops_seen;
        offer(30, 48'h3000, 100, n, ml);
        check("t3_accepted", 64'(n), 64'(30));
        check("t3_stall_len", 64'(ml), 64'(1));
        idle(15);
        check("t3_all_out", 64'(pops_seen - p0), 64'(30));

        // Pointer wrap with flag thresholds.
        p0 = pops_seen;
        ready_for_output = 1'b0;
        offer(7, 48'h4000, 30, n, ml);
        check("t4_fill", 64'(n), 64'(7));
        check("t4_af_set", 64'(almost_full), 64'(1));
        ready_for_output = 1'b1;
        idle(15);
        check("t4_ae_set", 64'(almost_empty), 64'(1));
        offer(13, 48'h4007, 60, n, ml);
        check("t4_rest", 64'(n), 64'(13));
        idle(15);
        check("t4_all_out", 64'(pops_seen - p0), 64'(20));

        // Flush with a read in flight.
        ready_for_output = 1'b0;
        offer(5, 48'h5000, 30, n, ml);
        idle(4);
        ready_for_output = 1'b1;
        tick();
        ready_for_output = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t5_ov_after_flush", 64'(output_valid), 64'(0));
        check("t5_rfi_after_flush", 64'(ready_for_input), 64'(1));
        check("t5_dout_after_flush", 64'(data_out), 64'(0));
        tick();
        check("t5_no_stale", 64'(output_valid), 64'(0));
        offer(1, 48'hABCD, 5, n, ml);
        wait_ov("t5_timeout");
        check("t5_first_word", 64'(data_out), 64'(48'hABCD));
        ready_for_output = 1'b1;
        idle(3);

        // Full-width word across 3 banks, then reset mid-stream.
        offer(1, 48'h123456789ABC, 5, n, ml);
        wait_ov("t6_timeout");
        check("t6_wide_word", 64'(data_out), 64'(48'h123456789ABC));
        ready_for_output = 1'b0;
        offer(4, 48'h6000, 10, n, ml);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_rfi", 64'(ready_for_input), 64'(1));
        check("t6_ov", 64'(output_valid), 64'(0));
        check("t6_dout", 64'(data_out), 64'(0));
        check("t6_count", 64'(element_count), 64'(0));
        check("t6_empty", 64'(fifo_empty), 64'(1));
        check("t6_full", 64'(fifo_full), 64'(0));
        check("t6_af", 64'(almost_full), 64'(0));
        check("t6_ae", 64'(almost_empty), 64'(1));
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
